// File: rtl/tour_pkg.sv
// tour_pkg -- shared types and constants for the knight's tour command sequencer.
//   tour_state_e : sequencer states
//   OP_*         : command opcodes (upper nibble of a 16-bit command)
//   HDG_*        : heading byte for each compass direction
//   RESP_*       : response bytes returned to the UART wrapper
package tour_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEG1_ISSUE,
        LEG1_WAIT,
        LEG2_ISSUE,
        LEG2_WAIT
    } tour_state_e;

    localparam logic [3:0] OP_MOVE         = 4'b0010;
    localparam logic [3:0] OP_MOVE_FANFARE = 4'b0011;

    localparam logic [7:0] HDG_N = 8'h00;
    localparam logic [7:0] HDG_W = 8'h3F;
    localparam logic [7:0] HDG_S = 8'h7F;
    localparam logic [7:0] HDG_E = 8'hBF;

    localparam logic [7:0] RESP_ACK  = 8'h5A;
    localparam logic [7:0] RESP_DONE = 8'hA5;

    // Build a command word: {opcode, heading, squares}.
    function automatic logic [15:0] make_cmd(input logic [3:0] op,
                                             input logic [7:0] hdg,
                                             input logic [3:0] sq);
        return {op, hdg, sq};
    endfunction

endpackage

// File: rtl/knight_leg_decode.sv
// knight_leg_decode -- splits a one-hot knight move into two straight-line legs.
//   mv_reg_i   : one-hot knight move
//   leg1_cmd_o : Y-axis leg command (plain move opcode)
//   leg2_cmd_o : X-axis leg command (move + fanfare opcode)
//   legal_o    : 1 when mv_reg_i is exactly one-hot
module knight_leg_decode
    import tour_pkg::*;
(
    input  logic [7:0]  mv_reg_i,
    output logic [15:0] leg1_cmd_o,
    output logic [15:0] leg2_cmd_o,
    output logic        legal_o
);

    always_comb begin
        leg1_cmd_o = 16'h0000;
        leg2_cmd_o = 16'h0000;
        legal_o    = 1'b0;
        // Only the eight exactly-one-hot codes match; anything else is illegal.
        case (mv_reg_i)
            8'h01: begin legal_o = 1'b1; leg1_cmd_o = make_cmd(OP_MOVE, HDG_N, 4'd2); leg2_cmd_o = make_cmd(OP_MOVE_FANFARE, HDG_W, 4'd1); end
            8'h02: begin legal_o = 1'b1; leg1_cmd_o = make_cmd(OP_MOVE, HDG_N, 4'd2); leg2_cmd_o = make_cmd(OP_MOVE_FANFARE, HDG_E, 4'd1); end
            8'h04: begin legal_o = 1'b1; leg1_cmd_o = make_cmd(OP_MOVE, HDG_N, 4'd1); leg2_cmd_o = make_cmd(OP_MOVE_FANFARE, HDG_W, 4'd2); end
            8'h08: begin legal_o = 1'b1; leg1_cmd_o = make_cmd(OP_MOVE, HDG_S, 4'd1); leg2_cmd_o = make_cmd(OP_MOVE_FANFARE, HDG_W, 4'd2); end
            8'h10: begin legal_o = 1'b1; leg1_cmd_o = make_cmd(OP_MOVE, HDG_S, 4'd2); leg2_cmd_o = make_cmd(OP_MOVE_FANFARE, HDG_W, 4'd1); end
            8'h20: begin legal_o = 1'b1; leg1_cmd_o = make_cmd(OP_MOVE, HDG_S, 4'd2); leg2_cmd_o = make_cmd(OP_MOVE_FANFARE, HDG_E, 4'd1); end
            8'h40: begin legal_o = 1'b1; leg1_cmd_o = make_cmd(OP_MOVE, HDG_S, 4'd1); leg2_cmd_o = make_cmd(OP_MOVE_FANFARE, HDG_E, 4'd2); end
            8'h80: begin legal_o = 1'b1; leg1_cmd_o = make_cmd(OP_MOVE, HDG_N, 4'd1); leg2_cmd_o = make_cmd(OP_MOVE_FANFARE, HDG_E, 4'd2); end
            default: ;
        endcase
    end

endmodule

// File: rtl/tour_cmd.sv
// tour_cmd -- sequences a knight's tour into motion commands, sharing the command
// processor interface with the UART path.
//   clk, rst                        : clock, synchronous active-high reset
//   cmd_UART, cmd_rdy_UART          : command from UART wrapper (passed through in IDLE)
//   clr_cmd_rdy_UART                : consume strobe back to UART wrapper (IDLE only)
//   tour_go                         : 1-clk start pulse
//   move / mv_indx                  : solver memory read data / address
//   cmd, cmd_rdy, clr_cmd_rdy       : command handshake to command processor;
//                                     cmd_rdy stays high until clr_cmd_rdy consumes cmd
//   send_resp                       : command processor finished the current command
//   resp                            : response byte for UART wrapper
//   tour_busy, tour_err             : tour owns the interface / illegal move pulse
module tour_cmd
    import tour_pkg::*;
#(
    parameter int NUM_MOVES = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    output logic        clr_cmd_rdy_UART,
    input  logic        tour_go,
    input  logic [7:0]  move,
    output logic [4:0]  mv_indx,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic [7:0]  resp,
    output logic        tour_busy,
    output logic        tour_err
);

    localparam logic [4:0] LAST_IDX = 5'(NUM_MOVES - 1);

    tour_state_e state_q, state_d;
    logic [4:0]  mv_indx_q, mv_indx_d;
    logic [7:0]  mv_reg_q, mv_reg_d;
    logic        cmd_rdy_q, cmd_rdy_d;
    logic        tour_err_q, tour_err_d;
    // ld_q: mv_indx just advanced, memory data for the new index is valid this cycle.
    // chk_q: mv_reg freshly latched, legality not yet checked; cmd_rdy held low.
    logic        ld_q, ld_d;
    logic        chk_q, chk_d;

    logic [15:0] leg1_cmd, leg2_cmd;
    logic        leg_legal;
    logic        last_move;

    knight_leg_decode u_decode (
        .mv_reg_i   (mv_reg_q),
        .leg1_cmd_o (leg1_cmd),
        .leg2_cmd_o (leg2_cmd),
        .legal_o    (leg_legal)
    );

    assign last_move = (mv_indx_q == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            mv_indx_q  <= 5'd0;
            mv_reg_q   <= 8'h00;
            cmd_rdy_q  <= 1'b0;
            tour_err_q <= 1'b0;
            ld_q       <= 1'b0;
            chk_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mv_indx_q  <= mv_indx_d;
            mv_reg_q   <= mv_reg_d;
            cmd_rdy_q  <= cmd_rdy_d;
            tour_err_q <= tour_err_d;
            ld_q       <= ld_d;
            chk_q      <= chk_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        mv_indx_d        = mv_indx_q;
        mv_reg_d         = mv_reg_q;
        cmd_rdy_d        = cmd_rdy_q;
        tour_err_d       = 1'b0;
        ld_d             = ld_q;
        chk_d            = chk_q;
        cmd              = cmd_UART;
        cmd_rdy          = cmd_rdy_q;
        clr_cmd_rdy_UART = 1'b0;
        resp             = RESP_ACK;
        tour_busy        = 1'b1;

        case (state_q)
            IDLE: begin
                cmd              = cmd_UART;
                cmd_rdy          = cmd_rdy_UART;
                clr_cmd_rdy_UART = clr_cmd_rdy;
                resp             = RESP_DONE;
                tour_busy        = 1'b0;
                if (tour_go) begin
                    mv_indx_d = 5'd0;
                    mv_reg_d  = move;
                    chk_d     = 1'b1;
                    cmd_rdy_d = 1'b0;
                    state_d   = LEG1_ISSUE;
                end
            end
            LEG1_ISSUE: begin
                cmd = leg1_cmd;
                if (ld_q) begin
                    mv_reg_d = move;
                    ld_d     = 1'b0;
                    chk_d    = 1'b1;
                end else if (chk_q) begin
                    chk_d = 1'b0;
                    if (leg_legal) begin
                        cmd_rdy_d = 1'b1;
                    end else begin
                        tour_err_d = 1'b1;
                        state_d    = IDLE;
                    end
                end else if (cmd_rdy_q && clr_cmd_rdy) begin
                    cmd_rdy_d = 1'b0;
                    state_d   = LEG1_WAIT;
                end
            end
            LEG1_WAIT: begin
                cmd = leg1_cmd;
                if (send_resp) begin
                    cmd_rdy_d = 1'b1;
                    state_d   = LEG2_ISSUE;
                end
            end
            LEG2_ISSUE: begin
                cmd = leg2_cmd;
                if (cmd_rdy_q && clr_cmd_rdy) begin
                    cmd_rdy_d = 1'b0;
                    state_d   = LEG2_WAIT;
                end
            end
            LEG2_WAIT: begin
                cmd = leg2_cmd;
                if (send_resp) begin
                    if (last_move) begin
                        resp    = RESP_DONE;
                        state_d = IDLE;
                    end else begin
                        mv_indx_d = mv_indx_q + 5'd1;
                        ld_d      = 1'b1;
                        state_d   = LEG1_ISSUE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mv_indx  = mv_indx_q;
    assign tour_err = tour_err_q;

endmodule

// File: tb/tb_tour_cmd.sv
// Directed bench for tour_cmd: a 24-move instance for decode / passthrough / reset
// scenarios and a 2-move instance for a complete tour. Both share the stimulus.
module tb_tour_cmd;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cmd_UART;
    logic        cmd_rdy_UART;
    logic        tour_go;
    logic [7:0]  move;
    logic        clr_cmd_rdy;
    logic        send_resp;

    logic        clr_uart_a, clr_uart_b;
    logic [4:0]  mv_indx_a, mv_indx_b;
    logic [15:0] cmd_a, cmd_b;
    logic        cmd_rdy_a, cmd_rdy_b;
    logic [7:0]  resp_a, resp_b;
    logic        busy_a, busy_b;
    logic        err_a, err_b;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    tour_cmd dut (
        .clk(clk), .rst(rst), .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART),
        .clr_cmd_rdy_UART(clr_uart_a), .tour_go(tour_go), .move(move),
        .mv_indx(mv_indx_a), .cmd(cmd_a), .cmd_rdy(cmd_rdy_a),
        .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp), .resp(resp_a),
        .tour_busy(busy_a), .tour_err(err_a)
    );

    tour_cmd #(.NUM_MOVES(2)) dut2 (
        .clk(clk), .rst(rst), .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART),
        .clr_cmd_rdy_UART(clr_uart_b), .tour_go(tour_go), .move(move),
        .mv_indx(mv_indx_b), .cmd(cmd_b), .cmd_rdy(cmd_rdy_b),
        .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp), .resp(resp_b),
        .tour_busy(busy_b), .tour_err(err_b)
    );

    // Monitors: rising edges of dut2 cmd_rdy, and any cmd_rdy high on dut.
    int   issued_b = 0;
    logic prev_rdy_b = 1'b0;
    logic seen_rdy_a = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            issued_b   = 0;
            prev_rdy_b = 1'b0;
            seen_rdy_a = 1'b0;
        end else begin
            if (cmd_rdy_b && !prev_rdy_b) issued_b++;
            prev_rdy_b = cmd_rdy_b;
            if (cmd_rdy_a) seen_rdy_a = 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; cmd_UART = 16'h0000; cmd_rdy_UART = 1'b0; tour_go = 1'b0;
        move = 8'h00; clr_cmd_rdy = 1'b0; send_resp = 1'b0;
        tick(); tick();
        rst = 1'b0;
        #1;
    endtask

    // Start pulse plus the legality-check cycle; cmd_rdy is up afterwards if legal.
    task automatic go(input logic [7:0] m);
        move = m; tour_go = 1'b1;
        tick();
        tour_go = 1'b0;
        tick();
    endtask

    task automatic ack();
        clr_cmd_rdy = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
        #1;
    endtask

    task automatic done_leg();
        send_resp = 1'b1;
        tick();
        send_resp = 0;
        #1;
    endtask

    // After a non-final leg2 completion: present next move, latch, check.
    task automatic advance(input logic [7:0] m);
        move = m;
        tick(); tick();
    endtask

    typedef struct {
        logic [15:0] c_uart; logic rdy_uart; logic clr;
        logic [15:0] e_cmd;  logic e_rdy;    logic e_clr_uart;
    } idle_vec_t;

    typedef struct {
        logic [7:0] m; logic [15:0] e_leg1; logic [15:0] e_leg2;
    } dec_vec_t;

    idle_vec_t idle_tab[4];
    dec_vec_t  dec_tab[8];
    logic [7:0] bad_tab[3];

    initial begin
        idle_tab[0] = '{16'h2003, 1'b1, 1'b1, 16'h2003, 1'b1, 1'b1};
        idle_tab[1] = '{16'h1234, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b0};
        idle_tab[2] = '{16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        idle_tab[3] = '{16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1};

        dec_tab[0] = '{8'h01, 16'h2002, 16'h33F1};
        dec_tab[1] = '{8'h02, 16'h2002, 16'h3BF1};
        dec_tab[2] = '{8'h04, 16'h2001, 16'h33F2};
        dec_tab[3] = '{8'h08, 16'h27F1, 16'h33F2};
        dec_tab[4] = '{8'h10, 16'h27F2, 16'h33F1};
        dec_tab[5] = '{8'h20, 16'h27F2, 16'h3BF1};
        dec_tab[6] = '{8'h40, 16'h27F1, 16'h3BF2};
        dec_tab[7] = '{8'h80, 16'h2001, 16'h3BF2};

        bad_tab[0] = 8'h03;
        bad_tab[1] = 8'h00;
        bad_tab[2] = 8'hFF;

        // Reset state
        do_reset();
        check("rst_mv_indx", 32'(mv_indx_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_err", 32'(err_a), 32'd0);
        check("rst_resp", 32'(resp_a), 32'hA5);
        check("rst_cmd_rdy", 32'(cmd_rdy_a), 32'd0);

        // IDLE passthrough
        foreach (idle_tab[i]) begin
            cmd_UART = idle_tab[i].c_uart; cmd_rdy_UART = idle_tab[i].rdy_uart;
            clr_cmd_rdy = idle_tab[i].clr;
            #1;
            check($sformatf("idle_cmd[%0d]", i), 32'(cmd_a), 32'(idle_tab[i].e_cmd));
            check($sformatf("idle_rdy[%0d]", i), 32'(cmd_rdy_a), 32'(idle_tab[i].e_rdy));
            check($sformatf("idle_clr[%0d]", i), 32'(clr_uart_a), 32'(idle_tab[i].e_clr_uart));
            check($sformatf("idle_resp[%0d]", i), 32'(resp_a), 32'hA5);
        end

        // Decode of every legal move, first move of a tour
        foreach (dec_tab[i]) begin
            do_reset();
            go(dec_tab[i].m);
            check($sformatf("leg1_cmd[%0d]", i), 32'(cmd_a), 32'(dec_tab[i].e_leg1));
            check($sformatf("leg1_rdy[%0d]", i), 32'(cmd_rdy_a), 32'd1);
            ack();
            check($sformatf("wait1_rdy[%0d]", i), 32'(cmd_rdy_a), 32'd0);
            check($sformatf("wait1_cmd[%0d]", i), 32'(cmd_a), 32'(dec_tab[i].e_leg1));
            done_leg();
            check($sformatf("leg2_cmd[%0d]", i), 32'(cmd_a), 32'(dec_tab[i].e_leg2));
            check($sformatf("leg2_rdy[%0d]", i), 32'(cmd_rdy_a), 32'd1);
            ack();
            done_leg();
            check($sformatf("next_idx[%0d]", i), 32'(mv_indx_a), 32'd1);
        end

        // UART side ignored during tour; send_resp ignored in ISSUE
        do_reset();
        go(8'h01);
        cmd_UART = 16'hDEAD; cmd_rdy_UART = 1'b1;
        #1;
        check("tour_cmd_hold", 32'(cmd_a), 32'h2002);
        done_leg();
        check("issue_ignores_resp_rdy", 32'(cmd_rdy_a), 32'd1);
        check("issue_ignores_resp_cmd", 32'(cmd_a), 32'h2002);
        clr_cmd_rdy = 1'b1;
        #1;
        check("tour_no_clr_uart", 32'(clr_uart_a), 32'd0);
        tick();
        clr_cmd_rdy = 1'b0;
        #1;
        check("wait_rdy_low", 32'(cmd_rdy_a), 32'd0);
        send_resp = 1'b1;
        #1;
        check("mid_resp_ack", 32'(resp_a), 32'h5A);
        tick();
        send_resp = 1'b0;
        #1;
        check("leg2_cmd_0x01", 32'(cmd_a), 32'h33F1);
        check("busy_resp", 32'(resp_a), 32'h5A);
        check("busy_high", 32'(busy_a), 32'd1);
        cmd_rdy_UART = 1'b0;

        // Illegal encodings at latch
        foreach (bad_tab[i]) begin
            do_reset();
            move = bad_tab[i]; tour_go = 1'b1;
            tick();
            tour_go = 1'b0;
            #1;
            check($sformatf("bad_chk_rdy[%0d]", i), 32'(cmd_rdy_a), 32'd0);
            tick();
            check($sformatf("bad_err[%0d]", i), 32'(err_a), 32'd1);
            check($sformatf("bad_idle[%0d]", i), 32'(busy_a), 32'd0);
            tick();
            check($sformatf("bad_err_pulse[%0d]", i), 32'(err_a), 32'd0);
            tick();
            check($sformatf("bad_never_rdy[%0d]", i), 32'(seen_rdy_a), 32'd0);
        end

        // Full 2-move tour on dut2
        do_reset();
        go(8'h01);
        check("t2_leg1a", 32'(cmd_b), 32'h2002);
        ack(); done_leg();
        check("t2_leg2a", 32'(cmd_b), 32'h33F1);
        ack(); done_leg();
        check("t2_idx1", 32'(mv_indx_b), 32'd1);
        advance(8'h40);
        check("t2_leg1b", 32'(cmd_b), 32'h27F1);
        check("t2_leg1b_rdy", 32'(cmd_rdy_b), 32'd1);
        ack(); done_leg();
        check("t2_leg2b", 32'(cmd_b), 32'h3BF2);
        ack();
        send_resp = 1'b1;
        #1;
        check("t2_final_resp", 32'(resp_b), 32'hA5);
        check("t2_busy_final", 32'(busy_b), 32'd1);
        tick();
        send_resp = 1'b0;
        #1;
        check("t2_busy_drop", 32'(busy_b), 32'd0);
        check("t2_idx_nowrap", 32'(mv_indx_b), 32'd1);
        tick();
        check("t2_issued", 32'(issued_b), 32'd4);

        // Reset in the middle of a tour at mv_indx=5
        do_reset();
        go(8'h01);
        for (int k = 0; k < 5; k++) begin
            ack(); done_leg(); ack(); done_leg();
            advance(8'h01);
        end
        check("mid_idx5", 32'(mv_indx_a), 32'd5);
        ack(); done_leg(); ack();
        check("mid_wait_rdy", 32'(cmd_rdy_a), 32'd0);
        move = 8'h40; tour_go = 1'b1;
        tick();
        tour_go = 1'b0;
        #1;
        check("go_ignored_idx", 32'(mv_indx_a), 32'd5);
        check("go_ignored_cmd", 32'(cmd_a), 32'h33F1);
        check("go_ignored_busy", 32'(busy_a), 32'd1);
        cmd_UART = 16'h1357;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("mid_rst_idx", 32'(mv_indx_a), 32'd0);
        check("mid_rst_rdy", 32'(cmd_rdy_a), 32'd0);
        check("mid_rst_busy", 32'(busy_a), 32'd0);
        check("mid_rst_resp", 32'(resp_a), 32'hA5);
        check("mid_rst_cmd", 32'(cmd_a), 32'h1357);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
